wb_burst_reader: RTL and testbench

WB_BURST_READER -- requirements
Module: wb_burst_reader

---
 rtl/wb_reader_pkg.sv | 22 ++
 rtl/wshb_if.sv | 33 +++
 rtl/sync_fifo.sv | 57 +++++
 rtl/wb_burst_reader.sv | 154 +++++++++++++++
 tb/tb_wb_burst_reader.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_reader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_reader_pkg
// Description : Shared Wishbone cycle-type codes and reader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_reader_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ROOM = 2'd1,
        ST_BURST     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wshb_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wshb_if
// Description : Wishbone B4 bus bundle with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;

    modport master (
        input  clk, rst, dat_sm, ack,
        output cyc, stb, we, sel, adr, cti, bte, dat_ms
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, cti, bte, dat_ms,
        output dat_sm, ack
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO, power-of-two depth.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    // Output forced to zero while empty so stale storage never shows on dout
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/wb_burst_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_burst_reader
// Description : Reads NB_WORDS words from BASE_ADR with aligned Wishbone bursts
//               into a streaming FIFO, fetching only when room is available.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_burst_reader
    import wb_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          NB_WORDS   = 1024,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 32
) (
    wshb_if.master          wb_m,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [31:0]     dout,
    output logic            dout_valid,
    input  logic            dout_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_words_left;
    logic [31:0]   r_beats_left;
    logic [29:0]   r_wadr;
    logic [2:0]    r_cti;
    logic          r_cyc;
    logic          r_busy;
    logic          r_done;

    logic [31:0]   w_burst_len;
    logic [31:0]   w_free;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_load;
    logic          w_launch;
    logic          w_fifo_wr;
    logic          w_last_beat;

    // Bursts start on BURST_LEN multiples from the base, so only the tail is short
    assign w_burst_len = (r_words_left > 32'(BURST_LEN)) ? 32'(BURST_LEN) : r_words_left;
    assign w_free      = 32'(FIFO_DEPTH) - 32'(w_count);

    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_launch     = 1'b0;
        w_fifo_wr    = 1'b0;
        w_last_beat  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_WAIT_ROOM;
                end
            end
            ST_WAIT_ROOM: begin
                if (w_free >= w_burst_len) begin
                    w_launch     = 1'b1;
                    w_state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                if (wb_m.ack && !w_full) begin
                    w_fifo_wr = 1'b1;
                    if (r_beats_left == 32'd1) begin
                        w_last_beat  = 1'b1;
                        w_state_next = (r_words_left == 32'd1) ? ST_IDLE : ST_WAIT_ROOM;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_m.clk) begin
        if (wb_m.rst) begin
            r_cyc        <= 1'b0;
            r_cti        <= CTI_CLASSIC;
            r_wadr       <= BASE_ADR[31:2];
            r_words_left <= '0;
            r_beats_left <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_wadr       <= BASE_ADR[31:2];
                r_words_left <= 32'(NB_WORDS);
                r_busy       <= 1'b1;
            end
            if (w_launch) begin
                r_cyc        <= 1'b1;
                r_beats_left <= w_burst_len;
                r_cti        <= (w_burst_len == 32'd1) ? CTI_END : CTI_INCR;
            end
            if (w_fifo_wr) begin
                r_wadr       <= r_wadr + 30'd1;
                r_words_left <= r_words_left - 32'd1;
                r_beats_left <= r_beats_left - 32'd1;
                if (r_beats_left == 32'd2) r_cti <= CTI_END;
            end
            if (w_last_beat) begin
                r_cyc <= 1'b0;
                r_cti <= CTI_CLASSIC;
                if (r_words_left == 32'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_m.clk),
        .rst       (wb_m.rst),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (wb_m.dat_sm),
        .i_rd_en   (dout_ready),
        .o_rd_data (dout),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (w_count)
    );

    assign wb_m.cyc    = r_cyc;
    assign wb_m.stb    = r_cyc;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'b1111;
    assign wb_m.adr    = {r_wadr, 2'b00};
    assign wb_m.cti    = r_cti;
    assign wb_m.bte    = BTE_LINEAR;
    assign wb_m.dat_ms = '0;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dout_valid  = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_burst_reader
// Description : Randomised scoreboard bench for wb_burst_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_burst_reader;

    localparam logic [31:0] BASE0  = 32'hFFFF_FFC0;
    localparam int          NB0    = 36;
    localparam int          BL0    = 16;
    localparam int          DEPTH0 = 32;
    localparam logic [31:0] BASE1  = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wshb_if bus0 (.clk(clk), .rst(rst));
    wshb_if bus1 (.clk(clk), .rst(rst));

    logic        start0 = 1'b0, rdy0 = 1'b0, busy0, done0, dv0;
    logic [31:0] dout0;
    logic        start1 = 1'b0, rdy1 = 1'b1, busy1, done1, dv1;
    logic [31:0] dout1;

    wb_burst_reader #(.BASE_ADR(BASE0), .NB_WORDS(NB0), .BURST_LEN(BL0), .FIFO_DEPTH(DEPTH0)) u_dut0 (
        .wb_m(bus0), .start(start0), .busy(busy0), .done(done0),
        .dout(dout0), .dout_valid(dv0), .dout_ready(rdy0)
    );

    wb_burst_reader #(.BASE_ADR(BASE1), .NB_WORDS(1), .BURST_LEN(4), .FIFO_DEPTH(4)) u_dut1 (
        .wb_m(bus1), .start(start1), .busy(busy1), .done(done1),
        .dout(dout1), .dout_valid(dv1), .dout_ready(rdy1)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_data[$];
    logic [31:0] seed;
    int  n_checks = 0, n_fail = 0, cnt = 0;
    int  done_due = -1, beats_seen = 0;
    bit  model_busy = 0, expect_cyc_low = 0, stray_en = 0;
    int  wait_mode = 0, ready_mode = 1, wcnt = 0, wtarget = 0;

    always @(posedge clk) cnt <= cnt + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic int pick_wait();
        if (wait_mode == 0) return 0;
        if (wait_mode == 1) return 2;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave for DUT0: programmable wait states, optional stray acks when idle
    always @(posedge clk) begin
        #1;
        if (bus0.cyc && bus0.stb) begin
            if (wcnt < wtarget) begin
                bus0.ack = 1'b0;
                wcnt++;
            end else begin
                bus0.ack    = 1'b1;
                bus0.dat_sm = mem_word(bus0.adr);
                wcnt        = 0;
                wtarget     = pick_wait();
            end
        end else begin
            wcnt        = 0;
            wtarget     = pick_wait();
            bus0.ack    = stray_en && ($urandom_range(0, 3) == 0);
            bus0.dat_sm = $urandom;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rdy0 = 1'b0;
            1:       rdy0 = 1'b1;
            default: rdy0 = 1'($urandom_range(0, 1));
        endcase
    end

    always @(posedge clk) begin
        #1;
        bus1.ack    = bus1.cyc;
        bus1.dat_sm = mem_word(bus1.adr);
    end

    // Monitor/scoreboard for DUT0
    always @(negedge clk) begin
        if (!rst) begin
            if (expect_cyc_low) begin
                chk("cyc_gap", {63'd0, bus0.cyc}, 64'd0);
                expect_cyc_low = 0;
            end else if (bus0.cyc) begin
                if (exp_beats.size() == 0) begin
                    chk("cyc_unexpected", {63'd0, bus0.cyc}, 64'd0);
                end else begin
                    chk("bus_beat", {29'd0, bus0.adr, bus0.cti}, {29'd0, exp_beats[0].adr, exp_beats[0].cti});
                    chk("bus_ctl", {56'd0, bus0.stb, bus0.we, bus0.sel, bus0.bte}, {56'd0, 1'b1, 1'b0, 4'hF, 2'b00});
                    if (bus0.ack) begin
                        if (exp_beats[0].cti == 3'b111) expect_cyc_low = 1;
                        void'(exp_beats.pop_front());
                        beats_seen++;
                        if (exp_beats.size() == 0) done_due = cnt + 1;
                    end
                end
            end
            if (cnt == done_due) model_busy = 0;
            chk("done", {63'd0, done0}, {63'd0, cnt == done_due});
            chk("busy", {63'd0, busy0}, {63'd0, model_busy});
            if (dv0 && rdy0) begin
                if (exp_data.size() == 0) chk("data_unexpected", {32'd0, dout0}, 64'hDEAD_0000_0000);
                else chk("data", {32'd0, dout0}, {32'd0, exp_data.pop_front()});
            end
        end
    end

    task automatic start_dut0();
        beat_t       b;
        logic [31:0] a;
        @(posedge clk); #1;
        start0     = 1'b1;
        beats_seen = 0;
        for (int i = 0; i < NB0; i++) begin
            a     = BASE0 + 32'(4 * i);
            b.adr = a;
            b.cti = ((i == NB0 - 1) || (i % BL0 == BL0 - 1)) ? 3'b111 : 3'b010;
            exp_beats.push_back(b);
            exp_data.push_back(mem_word(a));
        end
        @(posedge clk); #1;
        start0     = 1'b0;
        model_busy = 1;
    endtask

    task automatic finish_dut0(input int budget);
        int n = 0;
        while (model_busy && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (model_busy) chk("transfer_timeout", 64'(beats_seen), 64'(NB0));
        ready_mode = 1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("drain_valid", {63'd0, dv0}, 64'd0);
        chk("drain_left", 64'(exp_data.size()), 64'd0);
    endtask

    initial begin
        int n, n_cyc, n_words, n_done, ack_cyc, dv_cyc;
        seed = $urandom;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cyc",  {63'd0, bus0.cyc}, 64'd0);
        chk("rst_cti",  {61'd0, bus0.cti}, 64'd0);
        chk("rst_adr",  {32'd0, bus0.adr}, {32'd0, BASE0});
        chk("rst_flags", {61'd0, busy0, done0, dv0}, 64'd0);
        chk("rst_dout", {32'd0, dout0}, 64'd0);

        // Zero-wait, always ready
        wait_mode = 0; ready_mode = 1; stray_en = 0;
        start_dut0();
        finish_dut0(500);

        // Two wait states per beat
        wait_mode = 1;
        start_dut0();
        finish_dut0(1000);

        // Random waits, random ready, stray acks, start while busy
        wait_mode = 2; ready_mode = 2; stray_en = 1;
        start_dut0();
        repeat (8) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        finish_dut0(2000);
        stray_en = 0;

        // Backpressure: FIFO fills, reader parks with cyc low
        wait_mode = 0; ready_mode = 0;
        start_dut0();
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("bp_beats", 64'(beats_seen), 64'(DEPTH0));
        chk("bp_cyc", {63'd0, bus0.cyc}, 64'd0);
        chk("bp_busy", {63'd0, busy0}, 64'd1);
        ready_mode = 1;
        finish_dut0(500);

        // Reset during the fifth beat, then a fresh transfer
        wait_mode = 0;
        start_dut0();
        n = 0;
        while (beats_seen < 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid_reach", 64'(beats_seen), 64'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_beats.delete();
        exp_data.delete();
        model_busy = 0; done_due = -1; expect_cyc_low = 0;
        @(negedge clk);
        chk("rst_mid_cyc", {63'd0, bus0.cyc}, 64'd0);
        chk("rst_mid_flags", {62'd0, dv0, busy0}, 64'd0);
        chk("rst_mid_adr", {32'd0, bus0.adr}, {32'd0, BASE0});
        start_dut0();
        finish_dut0(500);

        // Single-word transfer on DUT1
        n_cyc = 0; n_words = 0; n_done = 0; ack_cyc = -10; dv_cyc = -20;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus1.cyc) begin
                n_cyc++;
                chk("one_cti", {61'd0, bus1.cti}, 64'd7);
                chk("one_adr", {32'd0, bus1.adr}, {32'd0, BASE1});
                if (bus1.ack) ack_cyc = cnt;
            end
            if (dv1) begin
                n_words++;
                dv_cyc = cnt;
                chk("one_data", {32'd0, dout1}, {32'd0, mem_word(BASE1)});
            end
            if (done1) n_done++;
        end
        chk("one_beats", 64'(n_cyc), 64'd1);
        chk("one_words", 64'(n_words), 64'd1);
        chk("one_done", 64'(n_done), 64'd1);
        chk("one_latency", 64'(dv_cyc - ack_cyc), 64'd1);
        chk("one_busy", {63'd0, busy1}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
